// File: rtl/cnn_dnn_pkg.sv
// Shared types and elaboration-time helpers for the CNN->DNN sequencer.
package cnn_dnn_pkg;

    // Upper bound on DNN depth; LNN is zero-extended to this many 32-bit slots
    // so the row-count helper can take a fixed-width argument.
    localparam int MaxLayers = 8;
    localparam int LnnBits   = MaxLayers * 32;

    // Pixel count of one frame for the default 8x8 image.
    localparam int DefaultImageWidth = 8;
    localparam int FramePixels       = DefaultImageWidth * DefaultImageWidth;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST,
        S_LOAD,
        S_STREAM,
        S_DRAIN
    } seq_state_t;

    // Weight-ROM rows: ImageSize rows for layer 0, then one row per neuron of
    // every earlier layer feeding a later one. Slot NumLayers-1 is the first layer.
    function automatic int total_rows(input int image_size, input int num_layers,
                                      input logic [LnnBits-1:0] lnn);
        int acc;
        acc = image_size;
        for (int k = 1; k < num_layers; k++) begin
            acc += int'(lnn[(num_layers - k) * 32 +: 32]);
        end
        return acc;
    endfunction

endpackage

// File: rtl/cnn_dnn_sequencer_pixel_skid.sv
// Single-entry valid/ready register between the upstream pixel source and top.
module pixel_skid
    import cnn_dnn_pkg::*;
#(
    parameter int Width = 4
) (
    input  logic             clk,
    input  logic             res,
    input  logic             en_i,
    input  logic             up_valid_i,
    output logic             up_ready_o,
    input  logic [Width-1:0] up_data_i,
    output logic             dn_valid_o,
    input  logic             dn_ready_i,
    output logic [Width-1:0] dn_data_o
);

    logic             valid_q, valid_d;
    logic [Width-1:0] data_q, data_d;

    // Accept a new pixel whenever the slot is empty or is being emptied this cycle.
    assign up_ready_o = en_i && (!valid_q || dn_ready_i);
    assign dn_valid_o = valid_q;
    assign dn_data_o  = data_q;

    // Load on an upstream handshake, otherwise drop the entry once downstream takes it.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (up_valid_i && up_ready_o) begin
            valid_d = 1'b1;
            data_d  = up_data_i;
        end else if (dn_ready_i) begin
            valid_d = 1'b0;
        end
    end

    // Slot register; data only changes on a load, so it is stable while stalled.
    always_ff @(posedge clk) begin
        if (res) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/cnn_dnn_sequencer.sv
// Drives the CNN->DNN pipeline: optional reset + weight load, then one pixel frame.
module cnn_dnn_sequencer
    import cnn_dnn_pkg::*;
#(
    parameter int BitSize      = 4,
    parameter int ImageWidth   = 8,
    parameter int ImageSize    = 4,
    parameter int M_W_BitSize  = 4,
    parameter int MaxNumNerves = 4,
    parameter int NumLayers    = 2,
    parameter logic [NumLayers-1:0][31:0] LNN = {32'd2, 32'd4},
    localparam int TotalRows   = total_rows(ImageSize, NumLayers, LnnBits'(LNN)),
    localparam int AddrW       = $clog2(TotalRows),
    localparam int WordW       = MaxNumNerves * M_W_BitSize
) (
    input  logic              clk,
    input  logic              res,
    input  logic              start,
    input  logic              reload,
    output logic              wmem_rd,
    output logic [AddrW-1:0]  wmem_addr,
    input  logic [WordW-1:0]  wmem_data,
    input  logic              pix_valid,
    output logic              pix_ready,
    input  logic [BitSize-1:0] pix_data,
    output logic              top_res_n,
    output logic [WordW-1:0]  in_weights,
    output logic              in_valid,
    output logic [BitSize-1:0] in_data,
    input  logic              out_ready,
    input  logic              out_done,
    output logic              busy,
    output logic              done,
    output logic [15:0]       frame_cnt
);

    localparam int FrameLen = ImageWidth * ImageWidth;
    localparam int CntW     = $clog2(FrameLen + 1);

    localparam logic [AddrW-1:0] RowLast    = AddrW'(TotalRows - 1);
    localparam logic [CntW-1:0]  FrameFull  = CntW'(FrameLen);
    localparam logic [CntW-1:0]  FrameLast  = CntW'(FrameLen - 1);

    seq_state_t       state_q, state_d;
    logic [AddrW-1:0] row_q, row_d;
    logic             loaded_q, loaded_d;
    logic [CntW-1:0]  taken_q, taken_d;
    logic [CntW-1:0]  xfer_q, xfer_d;
    logic             done_seen_q, done_seen_d;
    logic             done_q, done_d;
    logic [15:0]      frame_cnt_q, frame_cnt_d;

    logic             skid_en;
    logic             pix_take;
    logic             pix_xfer;

    // Upstream is only opened in STREAM and closed once the whole frame has been taken.
    assign skid_en  = (state_q == S_STREAM) && (taken_q != FrameFull);
    assign pix_take = pix_valid && pix_ready;
    assign pix_xfer = in_valid && out_ready;

    pixel_skid #(
        .Width (BitSize)
    ) u_skid (
        .clk        (clk),
        .res        (res),
        .en_i       (skid_en),
        .up_valid_i (pix_valid),
        .up_ready_o (pix_ready),
        .up_data_i  (pix_data),
        .dn_valid_o (in_valid),
        .dn_ready_i (out_ready),
        .dn_data_o  (in_data)
    );

    // top is held in reset by our own reset and for the single RST cycle.
    assign top_res_n = !(res || (state_q == S_RST));
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign frame_cnt = frame_cnt_q;

    // Next-state, counters and ROM/weight outputs.
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        loaded_d    = loaded_q;
        taken_d     = taken_q;
        xfer_d      = xfer_q;
        done_seen_d = done_seen_q;
        done_d      = 1'b0;
        frame_cnt_d = frame_cnt_q;
        wmem_rd     = 1'b0;
        wmem_addr   = '0;
        in_weights  = '0;

        case (state_q)
            S_IDLE: begin
                row_d       = '0;
                taken_d     = '0;
                xfer_d      = '0;
                done_seen_d = 1'b0;
                if (start) begin
                    // Streaming without weights in top is meaningless, so force a load.
                    state_d = (reload || !loaded_q) ? S_RST : S_STREAM;
                end
            end

            S_RST: begin
                // Prefetch row 0 so it is on wmem_data in the first LOAD cycle.
                loaded_d  = 1'b0;
                wmem_rd   = 1'b1;
                wmem_addr = '0;
                state_d   = S_LOAD;
            end

            S_LOAD: begin
                // Row row_q is on the ROM bus now; fetch the next one for the following cycle.
                in_weights = wmem_data;
                if (row_q == RowLast) begin
                    loaded_d = 1'b1;
                    state_d  = S_STREAM;
                end else begin
                    wmem_rd   = 1'b1;
                    wmem_addr = row_q + 1'b1;
                    row_d     = row_q + 1'b1;
                end
            end

            S_STREAM: begin
                if (pix_take) begin
                    taken_d = taken_q + 1'b1;
                end
                // top may finish as the last pixel lands; remember it for DRAIN.
                if (out_done) begin
                    done_seen_d = 1'b1;
                end
                if (pix_xfer) begin
                    xfer_d = xfer_q + 1'b1;
                    if (xfer_q == FrameLast) begin
                        state_d = S_DRAIN;
                    end
                end
            end

            S_DRAIN: begin
                if (out_done || done_seen_q) begin
                    done_d      = 1'b1;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    done_seen_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and counter registers; reset also forgets that weights were loaded.
    always_ff @(posedge clk) begin
        if (res) begin
            state_q     <= S_IDLE;
            row_q       <= '0;
            loaded_q    <= 1'b0;
            taken_q     <= '0;
            xfer_q      <= '0;
            done_seen_q <= 1'b0;
            done_q      <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            loaded_q    <= loaded_d;
            taken_q     <= taken_d;
            xfer_q      <= xfer_d;
            done_seen_q <= done_seen_d;
            done_q      <= done_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

endmodule

// File: tb/tb_cnn_dnn_sequencer.sv
// Self-checking bench for cnn_dnn_sequencer: weight load timing, pixel scoreboard, frame control.
module tb_cnn_dnn_sequencer;
    import cnn_dnn_pkg::*;

    localparam int NRows = 6;

    logic        clk = 1'b0;
    logic        res = 1'b1;
    logic        start = 1'b0;
    logic        reload = 1'b0;
    logic        wmem_rd;
    logic [2:0]  wmem_addr;
    logic [15:0] wmem_data = 16'hBAD0;
    logic        pix_valid = 1'b0;
    logic        pix_ready;
    logic [3:0]  pix_data = 4'h0;
    logic        top_res_n;
    logic [15:0] in_weights;
    logic        in_valid;
    logic [3:0]  in_data;
    logic        out_ready = 1'b0;
    logic        out_done = 1'b0;
    logic        busy;
    logic        done;
    logic [15:0] frame_cnt;

    int n_pass = 0;
    int n_total = 0;
    int exp_frames = 0;

    logic [15:0] rom [NRows] = '{16'h1000, 16'h0100, 16'h0000, 16'h0000, 16'h1010, 16'h0101};

    logic [3:0] exp_q [$];
    int         acc_cnt = 0;
    int         xfer_cnt = 0;
    logic       hold_prev = 1'b0;
    logic [3:0] data_prev = 4'h0;

    cnn_dnn_sequencer dut (
        .clk        (clk),
        .res        (res),
        .start      (start),
        .reload     (reload),
        .wmem_rd    (wmem_rd),
        .wmem_addr  (wmem_addr),
        .wmem_data  (wmem_data),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_data   (pix_data),
        .top_res_n  (top_res_n),
        .in_weights (in_weights),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .out_ready  (out_ready),
        .out_done   (out_done),
        .busy       (busy),
        .done       (done),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    // Weight ROM model: one-cycle read latency, garbage when not read.
    always @(posedge clk) begin
        if (wmem_rd) wmem_data <= rom[int'(wmem_addr)];
        else         wmem_data <= 16'hBAD0;
    end

    // Scoreboard: push on upstream handshake, pop and compare on transfer to top.
    always @(negedge clk) begin
        if (hold_prev) begin
            n_total++;
            if (in_valid !== 1'b1 || in_data !== data_prev)
                $display("FAIL stall_hold: in_valid=%b in_data=%h, required in_valid=1 in_data=%h", in_valid, in_data, data_prev);
            else n_pass++;
        end
        hold_prev = !res && in_valid && !out_ready;
        data_prev = in_data;
        if (pix_valid && pix_ready) begin
            exp_q.push_back(pix_data);
            acc_cnt++;
        end
        if (in_valid && out_ready) begin
            xfer_cnt++;
            n_total++;
            if (exp_q.size() == 0) begin
                $display("FAIL pixel_extra: transfer %0d data=%h, required no transfer (scoreboard empty)", xfer_cnt, in_data);
            end else begin
                logic [3:0] e;
                e = exp_q.pop_front();
                if (in_data !== e) $display("FAIL pixel_data: transfer %0d data=%h, required %h", xfer_cnt, in_data, e);
                else n_pass++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        res = 1'b1;
        tick();
        tick();
        n_total++;
        if (top_res_n !== 1'b0 || in_weights !== 16'h0 || in_valid !== 1'b0 || in_data !== 4'h0)
            $display("FAIL reset_datapath: top_res_n=%b in_weights=%h in_valid=%b in_data=%h, required 0/0000/0/0", top_res_n, in_weights, in_valid, in_data);
        else n_pass++;
        n_total++;
        if (wmem_rd !== 1'b0 || wmem_addr !== 3'd0 || pix_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || frame_cnt !== 16'd0)
            $display("FAIL reset_control: wmem_rd=%b wmem_addr=%0d pix_ready=%b busy=%b done=%b frame_cnt=%0d, required all 0", wmem_rd, wmem_addr, pix_ready, busy, done, frame_cnt);
        else n_pass++;
        res = 1'b0;
        exp_frames = 0;
        #1;
        n_total++;
        if (top_res_n !== 1'b1) $display("FAIL reset_release: top_res_n=%b, required 1", top_res_n);
        else n_pass++;
    endtask

    task automatic test_reload(input logic rl, input string tag);
        tick();
        start = 1'b1;
        reload = rl;
        tick();
        start = 1'b0;
        reload = 1'b0;
        #1;
        n_total++;
        if (top_res_n !== 1'b0 || wmem_rd !== 1'b1 || wmem_addr !== 3'd0 || busy !== 1'b1)
            $display("FAIL %s_rst: top_res_n=%b wmem_rd=%b wmem_addr=%0d busy=%b, required 0/1/0/1", tag, top_res_n, wmem_rd, wmem_addr, busy);
        else n_pass++;
        for (int j = 0; j < NRows; j++) begin
            tick();
            n_total++;
            if (in_weights !== rom[j] || top_res_n !== 1'b1)
                $display("FAIL %s_row%0d: in_weights=%h top_res_n=%b, required %h/1", tag, j, in_weights, top_res_n, rom[j]);
            else n_pass++;
        end
        tick();
        n_total++;
        if (in_weights !== 16'h0 || pix_ready !== 1'b1 || busy !== 1'b1)
            $display("FAIL %s_end: in_weights=%h pix_ready=%b busy=%b, required 0000/1/1", tag, in_weights, pix_ready, busy);
        else n_pass++;
    endtask

    task automatic test_stream_full();
        int nx;
        int first;
        int last;
        nx = 0;
        first = -1;
        last = -1;
        acc_cnt = 0;
        xfer_cnt = 0;
        exp_q.delete();
        pix_valid = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 300 && nx < FramePixels; c++) begin
            pix_data = 4'($urandom);
            #1;
            if (in_valid && out_ready) begin
                if (first < 0) first = c;
                last = c;
                nx++;
            end
            if (nx < FramePixels) tick();
        end
        n_total++;
        if (nx != FramePixels || (last - first + 1) != FramePixels)
            $display("FAIL full_burst: transfers=%0d span=%0d cycles, required %0d in %0d", nx, last - first + 1, FramePixels, FramePixels);
        else n_pass++;
        n_total++;
        if (pix_ready !== 1'b0) $display("FAIL full_closed: pix_ready=%b after last accept, required 0", pix_ready);
        else n_pass++;
        tick();
        tick();
        n_total++;
        if (in_valid !== 1'b0 || pix_ready !== 1'b0 || busy !== 1'b1 || done !== 1'b0 || acc_cnt != FramePixels || exp_q.size() != 0)
            $display("FAIL full_drain: in_valid=%b pix_ready=%b busy=%b done=%b accepted=%0d pending=%0d, required 0/0/1/0/%0d/0", in_valid, pix_ready, busy, done, acc_cnt, exp_q.size(), FramePixels);
        else n_pass++;
        pix_valid = 1'b0;
        out_done = 1'b1;
        tick();
        out_done = 1'b0;
        exp_frames++;
        n_total++;
        if (done !== 1'b1 || frame_cnt !== 16'(exp_frames) || busy !== 1'b0)
            $display("FAIL full_done: done=%b frame_cnt=%0d busy=%b, required 1/%0d/0", done, frame_cnt, busy, exp_frames);
        else n_pass++;
        tick();
        n_total++;
        if (done !== 1'b0) $display("FAIL full_done_pulse: done=%b, required 0", done);
        else n_pass++;
    endtask

    task automatic test_second_frame();
        tick();
        start = 1'b1;
        reload = 1'b0;
        tick();
        start = 1'b0;
        #1;
        n_total++;
        if (busy !== 1'b1 || top_res_n !== 1'b1 || wmem_rd !== 1'b0 || pix_ready !== 1'b1 || in_weights !== 16'h0)
            $display("FAIL second_start: busy=%b top_res_n=%b wmem_rd=%b pix_ready=%b in_weights=%h, required 1/1/0/1/0000", busy, top_res_n, wmem_rd, pix_ready, in_weights);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        int nx;
        int stalls;
        logic [3:0] pat;
        nx = 0;
        stalls = 0;
        pat = 4'b1001;
        acc_cnt = 0;
        xfer_cnt = 0;
        exp_q.delete();
        for (int c = 0; c < 800 && nx < FramePixels; c++) begin
            out_ready = pat[c % 4];
            pix_valid = ($urandom_range(0, 4) != 0);
            pix_data = 4'($urandom);
            #1;
            if (in_valid && out_ready) nx++;
            if (in_valid && !out_ready) stalls++;
            if (nx < FramePixels) tick();
        end
        n_total++;
        if (nx != FramePixels || stalls == 0)
            $display("FAIL bp_progress: transfers=%0d stalls=%0d, required %0d and >0", nx, stalls, FramePixels);
        else n_pass++;
        out_ready = 1'b1;
        pix_valid = 1'b1;
        tick();
        tick();
        n_total++;
        if (in_valid !== 1'b0 || pix_ready !== 1'b0 || acc_cnt != FramePixels || xfer_cnt != FramePixels || exp_q.size() != 0)
            $display("FAIL bp_count: in_valid=%b pix_ready=%b accepted=%0d transferred=%0d pending=%0d, required 0/0/%0d/%0d/0", in_valid, pix_ready, acc_cnt, xfer_cnt, exp_q.size(), FramePixels, FramePixels);
        else n_pass++;
        pix_valid = 1'b0;
        out_done = 1'b1;
        tick();
        out_done = 1'b0;
        exp_frames++;
        n_total++;
        if (done !== 1'b1 || frame_cnt !== 16'(exp_frames))
            $display("FAIL bp_done: done=%b frame_cnt=%0d, required 1/%0d", done, frame_cnt, exp_frames);
        else n_pass++;
    endtask

    task automatic test_res_mid_load();
        tick();
        start = 1'b1;
        reload = 1'b1;
        tick();
        start = 1'b0;
        reload = 1'b0;
        for (int j = 0; j < 4; j++) tick();
        n_total++;
        if (in_weights !== rom[3]) $display("FAIL midload_row3: in_weights=%h, required %h", in_weights, rom[3]);
        else n_pass++;
        res = 1'b1;
        tick();
        n_total++;
        if (top_res_n !== 1'b0 || busy !== 1'b0 || in_weights !== 16'h0 || frame_cnt !== 16'd0)
            $display("FAIL midload_res: top_res_n=%b busy=%b in_weights=%h frame_cnt=%0d, required 0/0/0000/0", top_res_n, busy, in_weights, frame_cnt);
        else n_pass++;
        res = 1'b0;
        exp_frames = 0;
        test_reload(1'b0, "reload_after_res");
    endtask

    task automatic test_done_latched();
        int nx;
        nx = 0;
        acc_cnt = 0;
        xfer_cnt = 0;
        exp_q.delete();
        out_ready = 1'b1;
        pix_valid = 1'b1;
        for (int c = 0; c < 300 && nx < FramePixels; c++) begin
            pix_data = 4'($urandom);
            start = (c == 10);
            reload = (c == 10);
            #1;
            if (c == 11) begin
                n_total++;
                if (busy !== 1'b1 || top_res_n !== 1'b1)
                    $display("FAIL start_ignored: busy=%b top_res_n=%b, required 1/1", busy, top_res_n);
                else n_pass++;
            end
            if (in_valid && out_ready) begin
                nx++;
                if (nx == FramePixels) out_done = 1'b1;
            end
            if (nx < FramePixels) tick();
        end
        n_total++;
        if (nx != FramePixels) $display("FAIL latch_progress: transfers=%0d, required %0d", nx, FramePixels);
        else n_pass++;
        tick();
        out_done = 1'b0;
        start = 1'b0;
        reload = 1'b0;
        pix_valid = 1'b0;
        n_total++;
        if (done !== 1'b0 || busy !== 1'b1)
            $display("FAIL latch_entry: done=%b busy=%b, required 0/1", done, busy);
        else n_pass++;
        tick();
        exp_frames++;
        n_total++;
        if (done !== 1'b1 || frame_cnt !== 16'(exp_frames) || busy !== 1'b0 || xfer_cnt != FramePixels)
            $display("FAIL latch_done: done=%b frame_cnt=%0d busy=%b transferred=%0d, required 1/%0d/0/%0d", done, frame_cnt, busy, xfer_cnt, exp_frames, FramePixels);
        else n_pass++;
        tick();
        n_total++;
        if (done !== 1'b0) $display("FAIL latch_pulse: done=%b, required 0", done);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_reload(1'b1, "reload");
        test_stream_full();
        test_second_frame();
        test_backpressure();
        test_res_mid_load();
        test_done_latched();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required bench to finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cnn_dnn_sequencer.md
# cnn_dnn_sequencer

Drives the `top` CNN→DNN pipeline in place of a testbench. On `start` it optionally resets `top` and fetches the DNN weight rows from a weight ROM. It then presents them on `in_weights` on back-to-back cycles, which is the only loading protocol `top` accepts. Finally it streams one frame of pixels from an upstream valid/ready source into `top` under `top`'s `out_ready` backpressure, and reports when `top` raises `out_done`.

## Interface
Parameters:
- `BitSize`, 4: pixel width.
- `ImageWidth`, 8: frame is `ImageWidth*ImageWidth` pixels.
- `ImageSize`, 4: flattened CNN outputs; row count of DNN layer 0.
- `M_W_BitSize`, 4: weight width.
- `MaxNumNerves`, 4: lanes per weight word.
- `NumLayers`, 2: DNN layers.
- `LNN`, `'{2,4}`: neurons per layer. `LNN[NumLayers-1]` is the first layer.

Ports:
- `clk` in 1: single clock, rising edge.
- `res` in 1: reset. Synchronous, active-high.
- `start` in 1: begin a frame. Sampled in IDLE only.
- `reload` in 1: sampled with `start`. 1 resets `top` and reloads weights; 0 streams the frame only.
- `wmem_rd` out 1: weight ROM read strobe.
- `wmem_addr` out `$clog2(TotalRows)`: ROM row address.
- `wmem_data` in `MaxNumNerves*M_W_BitSize`: ROM word, valid 1 cycle after `wmem_rd`. Lanes are preformatted and zero-padded.
- `pix_valid` in 1, `pix_ready` out 1, `pix_data` in `BitSize`: upstream pixel source.
- `top_res_n` out 1: reset to `top`, active-low.
- `in_weights` out `MaxNumNerves*M_W_BitSize`: to `top`.
- `in_valid` out 1, `in_data` out `BitSize`: pixel to `top`.
- `out_ready` in 1: `top` accepts a pixel this cycle.
- `out_done` in 1: `top` finished the frame.
- `busy` out 1: asserted outside IDLE.
- `done` out 1: one-cycle pulse at frame end.
- `frame_cnt` out 16: frames completed, wraps.

## Operation
- `TotalRows` = `ImageSize` + Σ`LNN[NumLayers-k]` for k = 1..NumLayers-1. Default is 4 + 2 = 6. The ROM stores layer 0 rows first, in row order.
- State IDLE:
  - `start && reload` → RST.
  - `start && !reload && weights_loaded` → STREAM.
  - `start && !reload && !weights_loaded` → behaves as `reload` = 1.
- State RST (1 cycle):
  - `top_res_n` = 0.
  - `wmem_rd` = 1 with `wmem_addr` = 0 (prefetch).
  - Next state is LOAD.
- State LOAD (`TotalRows` cycles):
  - Cycle j drives `in_weights` = ROM row j.
  - ROM row j+1 is issued in the same cycle, while j+1 < `TotalRows`.
  - After the last row: set `weights_loaded` and go to STREAM.
- State STREAM:
  - Holds a single-entry pixel register that drives `in_valid`/`in_data`.
  - `pix_ready` = `!in_valid || out_ready`.
  - `in_data` is stable while `in_valid && !out_ready`.
  - A pixel transfers to `top` on a cycle with `in_valid && out_ready`.
  - The pixel counter counts transfers.
  - `pix_ready` is forced to 0 once `ImageWidth²` pixels have been taken from upstream.
  - After transfer number `ImageWidth²`: `in_valid` = 0, go to DRAIN.
- State DRAIN: wait for `out_done`. When it is seen, pulse `done`, increment `frame_cnt`, return to IDLE.
- `out_done` arriving in STREAM is latched. DRAIN then exits in its first cycle.
- `start` outside IDLE is ignored.
- `res` clears `weights_loaded` from any state, including mid-LOAD and mid-STREAM.

## Timing
- Reset values:
  - State IDLE.
  - `top_res_n` = 0 while `res` is high; 1 otherwise outside RST.
  - `in_weights` = 0, `in_valid` = 0, `in_data` = 0.
  - `wmem_rd` = 0, `wmem_addr` = 0, `pix_ready` = 0.
  - `busy` = 0, `done` = 0, `frame_cnt` = 0.
- Reload path:
  - `start` sampled at edge t.
  - RST occupies cycle t+1.
  - Weight row 0 appears on `in_weights` at cycle t+2, the first cycle after `top_res_n` rises.
  - Rows arrive contiguously with no gaps.
  - `in_weights` returns to 0 after the last row.
- `pix_ready` first asserts in the cycle after LOAD ends. With `reload` = 0 it asserts in the cycle after `start`.
- Pixel latency: upstream handshake at cycle c → `in_valid` at c+1.
- Full throughput: 1 pixel/cycle when `out_ready` and `pix_valid` are held high.
- `done` is asserted the cycle after `out_done` is seen in DRAIN, or the cycle after entering DRAIN if `out_done` was already latched.

## Structure
- Package `cnn_dnn_pkg`:
  - State enum `seq_state_t`.
  - Function `total_rows(ImageSize, NumLayers, LNN)`.
  - Localparam `FramePixels`.
- Sub-module `pixel_skid`: single-entry valid/ready register for the pixel path.
- FSM, counters and ROM addressing live in the top level.

## Test plan
1. Defaults, `reload` = 1, ROM rows 0..5 = `0x1000, 0x0100, 0, 0, 0x1010, 0x0101` → `top_res_n` low exactly one cycle, then the six words on consecutive cycles starting t+2.
2. 64 pixels with `out_ready` held 1 and `pix_valid` 1 → 64 transfers in 64 consecutive cycles, then `pix_ready` = 0. The 65th upstream word is not consumed.
3. `out_ready` toggled 1,0,0,1 → `in_data` held across the stall, no pixel lost or duplicated. Checked against a 64-entry scoreboard.
4. Second frame with `reload` = 0 → no RST and no LOAD, STREAM the cycle after `start`, `frame_cnt` = 2 after `done`.
5. `res` pulsed mid-LOAD (row 3), then `start` with `reload` = 0 → full reload occurs, starting at row 0.
6. `out_done` asserted during the last STREAM transfer → `done` pulses the cycle after DRAIN entry, and `start` during STREAM is ignored.
